// File: rtl/alu_seq.sv
// Sequencer that issues one request to an external ALU, waits ALU_LAT cycles, captures results/flags.
// Optional ALU_SEQ_DIV0_TRAP_EN: reject divide-by-zero requests as invalid instead of issuing them.
module alu_seq #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_lo,
  output logic [15:0] rsp_hi,
  output logic        rsp_err,
  output logic        flag_c,
  output logic        flag_z,
  output logic        flag_o,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [7:0]  alu_op,
  output logic        alu_cf,
  input  logic [15:0] alu_acc,
  input  logic [15:0] alu_c,
  input  logic        alu_cflag,
  input  logic        alu_zflag,
  input  logic        alu_oflag
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [7:0]  op_q;
  logic        op_in_range;
  logic        div0;
  logic        issue;

  assign op_in_range = (req_op >= 8'h01) && (req_op <= 8'h11);

`ifdef ALU_SEQ_DIV0_TRAP_EN
  assign div0 = ((req_op == 8'h07) && (req_b[7:0] == 8'h00)) ||
                ((req_op == 8'h08) && (req_b == 16'h0000));
`else
  assign div0 = 1'b0;
`endif

  assign issue     = op_in_range && !div0;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign alu_cf    = flag_c;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = issue ? EXEC : DONE;
      EXEC: if (cnt_q == 3'd1) state_d = CAPT;
      CAPT: state_d = DONE;
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      op_q    <= 8'h00;
      alu_a   <= 16'h0000;
      alu_b   <= 16'h0000;
      alu_op  <= 8'h00;
      rsp_lo  <= 16'h0000;
      rsp_hi  <= 16'h0000;
      rsp_err <= 1'b0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      // alu_op is a one-cycle strobe; the ALU holds its outputs while it reads 0x00
      alu_op  <= 8'h00;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (issue) begin
              alu_a  <= req_a;
              alu_b  <= req_b;
              alu_op <= req_op;
              op_q   <= req_op;
              cnt_q  <= 3'(ALU_LAT);
            end else begin
              rsp_lo  <= 16'h0000;
              rsp_hi  <= 16'h0000;
              rsp_err <= 1'b1;
            end
          end
        end
        EXEC: cnt_q <= cnt_q - 3'd1;
        CAPT: begin
          rsp_lo  <= alu_acc;
          rsp_hi  <= ((op_q == 8'h06) || (op_q == 8'h08)) ? alu_c : 16'h0000;
          rsp_err <= 1'b0;
          if ((op_q >= 8'h01) && (op_q <= 8'h09)) begin
            flag_c <= alu_cflag;
            flag_z <= alu_zflag;
            flag_o <= alu_oflag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
